// File: rtl/apu_regfile.sv
// CPU-facing sound register file: decodes NR10-NR14, NR21-NR24 and NR50-NR52 and drives the
// pulse-channel fields and strobes directly from registers.
module apu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rd_valid,
  input  logic [3:0]  ch_active,
  input  logic        sq1_freqWb_en,
  input  logic [10:0] sq1_freqWb,
  output logic [2:0]  sq1_swpPd,
  output logic [2:0]  sq1_shift,
  output logic        sq1_negate,
  output logic [1:0]  sq1_duty,
  output logic [5:0]  sq1_lenLoad,
  output logic [3:0]  sq1_startVol,
  output logic        sq1_envAdd,
  output logic [2:0]  sq1_period,
  output logic [10:0] sq1_freq,
  output logic        sq1_lenEnable,
  output logic        sq1_trigger,
  output logic        sq1_lenStrobe,
  output logic [1:0]  sq2_duty,
  output logic [5:0]  sq2_lenLoad,
  output logic [3:0]  sq2_startVol,
  output logic        sq2_envAdd,
  output logic [2:0]  sq2_period,
  output logic [10:0] sq2_freq,
  output logic        sq2_lenEnable,
  output logic        sq2_trigger,
  output logic        sq2_lenStrobe,
  output logic [7:0]  nr50,
  output logic [7:0]  nr51,
  output logic        power
);

  localparam logic [7:0] AddrNr10 = 8'h10;
  localparam logic [7:0] AddrNr11 = 8'h11;
  localparam logic [7:0] AddrNr12 = 8'h12;
  localparam logic [7:0] AddrNr13 = 8'h13;
  localparam logic [7:0] AddrNr14 = 8'h14;
  localparam logic [7:0] AddrNr21 = 8'h16;
  localparam logic [7:0] AddrNr22 = 8'h17;
  localparam logic [7:0] AddrNr23 = 8'h18;
  localparam logic [7:0] AddrNr24 = 8'h19;
  localparam logic [7:0] AddrNr50 = 8'h24;
  localparam logic [7:0] AddrNr51 = 8'h25;
  localparam logic [7:0] AddrNr52 = 8'h26;

  typedef struct packed {
    logic [1:0]  duty;
    logic [5:0]  len_load;
    logic [3:0]  start_vol;
    logic        env_add;
    logic [2:0]  period;
    logic [10:0] freq;
    logic        len_en;
  } pulse_t;

  pulse_t      sq1_q, sq1_d, sq2_q, sq2_d;
  logic [6:0]  nr10_q, nr10_d;
  logic [7:0]  nr50_q, nr50_d, nr51_q, nr51_d;
  logic        power_q, power_d;
  logic        sq1_trig_q, sq1_trig_d, sq2_trig_q, sq2_trig_d;
  logic        sq1_lstb_q, sq1_lstb_d, sq2_lstb_q, sq2_lstb_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_valid_q;
  logic [7:0]  rd_mux;

  always_comb begin
    sq1_d      = sq1_q;
    sq2_d      = sq2_q;
    nr10_d     = nr10_q;
    nr50_d     = nr50_q;
    nr51_d     = nr51_q;
    power_d    = power_q;
    sq1_trig_d = 1'b0;
    sq2_trig_d = 1'b0;
    sq1_lstb_d = 1'b0;
    sq2_lstb_d = 1'b0;

    // Sweep write-back first so a same-cycle CPU write overrides only the bits it touches.
    if (power_q && sq1_freqWb_en) sq1_d.freq = sq1_freqWb;

    if (wr_en && (power_q || addr == AddrNr52)) begin
      case (addr)
        AddrNr10: nr10_d = wdata[6:0];
        AddrNr11: begin
          sq1_d.duty     = wdata[7:6];
          sq1_d.len_load = wdata[5:0];
          sq1_lstb_d     = 1'b1;
        end
        AddrNr12: {sq1_d.start_vol, sq1_d.env_add, sq1_d.period} = wdata;
        AddrNr13: sq1_d.freq[7:0] = wdata;
        AddrNr14: begin
          sq1_d.freq[10:8] = wdata[2:0];
          sq1_d.len_en     = wdata[6];
          sq1_trig_d       = wdata[7];
        end
        AddrNr21: begin
          sq2_d.duty     = wdata[7:6];
          sq2_d.len_load = wdata[5:0];
          sq2_lstb_d     = 1'b1;
        end
        AddrNr22: {sq2_d.start_vol, sq2_d.env_add, sq2_d.period} = wdata;
        AddrNr23: sq2_d.freq[7:0] = wdata;
        AddrNr24: begin
          sq2_d.freq[10:8] = wdata[2:0];
          sq2_d.len_en     = wdata[6];
          sq2_trig_d       = wdata[7];
        end
        AddrNr50: nr50_d = wdata;
        AddrNr51: nr51_d = wdata;
        AddrNr52: begin
          power_d = wdata[7];
          if (!wdata[7]) begin
            sq1_d  = '0;
            sq2_d  = '0;
            nr10_d = '0;
            nr50_d = '0;
            nr51_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Unreadable bits read back as 1.
  always_comb begin
    rd_mux = 8'hFF;
    case (addr)
      AddrNr10: rd_mux = {1'b1, nr10_q};
      AddrNr11: rd_mux = {sq1_q.duty, 6'h3F};
      AddrNr12: rd_mux = {sq1_q.start_vol, sq1_q.env_add, sq1_q.period};
      AddrNr13: rd_mux = 8'hFF;
      AddrNr14: rd_mux = {1'b1, sq1_q.len_en, 6'h3F};
      AddrNr21: rd_mux = {sq2_q.duty, 6'h3F};
      AddrNr22: rd_mux = {sq2_q.start_vol, sq2_q.env_add, sq2_q.period};
      AddrNr23: rd_mux = 8'hFF;
      AddrNr24: rd_mux = {1'b1, sq2_q.len_en, 6'h3F};
      AddrNr50: rd_mux = nr50_q;
      AddrNr51: rd_mux = nr51_q;
      AddrNr52: rd_mux = {power_q, 3'b111, ch_active};
      default:  rd_mux = 8'hFF;
    endcase
    rdata_d = rd_en ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq1_q      <= '0;
      sq2_q      <= '0;
      nr10_q     <= '0;
      nr50_q     <= '0;
      nr51_q     <= '0;
      power_q    <= 1'b0;
      sq1_trig_q <= 1'b0;
      sq2_trig_q <= 1'b0;
      sq1_lstb_q <= 1'b0;
      sq2_lstb_q <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sq1_q      <= sq1_d;
      sq2_q      <= sq2_d;
      nr10_q     <= nr10_d;
      nr50_q     <= nr50_d;
      nr51_q     <= nr51_d;
      power_q    <= power_d;
      sq1_trig_q <= sq1_trig_d;
      sq2_trig_q <= sq2_trig_d;
      sq1_lstb_q <= sq1_lstb_d;
      sq2_lstb_q <= sq2_lstb_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rdata         = rdata_q;
  assign rd_valid      = rd_valid_q;
  assign sq1_swpPd     = nr10_q[6:4];
  assign sq1_negate    = nr10_q[3];
  assign sq1_shift     = nr10_q[2:0];
  assign sq1_duty      = sq1_q.duty;
  assign sq1_lenLoad   = sq1_q.len_load;
  assign sq1_startVol  = sq1_q.start_vol;
  assign sq1_envAdd    = sq1_q.env_add;
  assign sq1_period    = sq1_q.period;
  assign sq1_freq      = sq1_q.freq;
  assign sq1_lenEnable = sq1_q.len_en;
  assign sq1_trigger   = sq1_trig_q;
  assign sq1_lenStrobe = sq1_lstb_q;
  assign sq2_duty      = sq2_q.duty;
  assign sq2_lenLoad   = sq2_q.len_load;
  assign sq2_startVol  = sq2_q.start_vol;
  assign sq2_envAdd    = sq2_q.env_add;
  assign sq2_period    = sq2_q.period;
  assign sq2_freq      = sq2_q.freq;
  assign sq2_lenEnable = sq2_q.len_en;
  assign sq2_trigger   = sq2_trig_q;
  assign sq2_lenStrobe = sq2_lstb_q;
  assign nr50          = nr50_q;
  assign nr51          = nr51_q;
  assign power         = power_q;

endmodule
